// File: rtl/guess_capture.sv
// Button capture for a guessing game: each raw button is synchronized and
// debounced, and every debounced press records the pressing channels into the
// next free slot of a per-channel bit pattern until all slots are used.
module guess_capture #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 7,
  parameter int unsigned DEB_CYCLES = 4,
  localparam int unsigned IW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       btn,
  input  logic                    clear,
  output logic [NUM_CH*DEPTH-1:0] pattern,
  output logic [IW-1:0]           idx,
  output logic                    done,
  output logic                    press,
  output logic [NUM_CH-1:0]       press_mask
);

  // Counter must hold 0..DEB_CYCLES-1; keep at least one bit when DEB_CYCLES is 1.
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [NUM_CH-1:0]       sync1_q, sync2_q;
  logic [NUM_CH-1:0]       deb_q, deb_d;
  logic [CW-1:0]           cnt_q [NUM_CH];
  logic [CW-1:0]           cnt_d [NUM_CH];
  logic [NUM_CH-1:0]       rise;
  logic [NUM_CH*DEPTH-1:0] pattern_q, pattern_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    press_q, press_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [DEPTH-1:0]        slot_oh;
  logic                    done_w;
  logic                    write;

  assign done_w = (idx_q == IW'(DEPTH));

  // Debounce: count edges of disagreement; toggle on the DEB_CYCLES-th one.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      deb_d[c] = deb_q[c];
      cnt_d[c] = '0;
      rise[c]  = 1'b0;
      if (sync2_q[c] != deb_q[c]) begin
        if (cnt_q[c] == CW'(DEB_CYCLES - 1)) begin
          deb_d[c] = ~deb_q[c];
          rise[c]  = ~deb_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  // Slot capture: any press while slots remain writes one slot; clear discards it.
  always_comb begin
    pattern_d = pattern_q;
    idx_d     = idx_q;
    press_d   = 1'b0;
    mask_d    = mask_q;
    write     = (|rise) && !done_w && !clear;
    for (int k = 0; k < DEPTH; k++) begin
      slot_oh[k] = (idx_q == IW'(k));
    end
    if (clear) begin
      pattern_d = '0;
      idx_d     = '0;
      mask_d    = '0;
    end else if (write) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (rise[c] && slot_oh[k]) begin
            pattern_d[c*DEPTH + k] = 1'b1;
          end
        end
      end
      idx_d   = idx_q + IW'(1);
      press_d = 1'b1;
      mask_d  = rise;
    end
  end

  // State registers; reset beats clear and any press on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      pattern_q <= '0;
      idx_q     <= '0;
      press_q   <= 1'b0;
      mask_q    <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      press_q   <= press_d;
      mask_q    <= mask_d;
    end
  end

  assign pattern    = pattern_q;
  assign idx        = idx_q;
  assign done       = done_w;
  assign press      = press_q;
  assign press_mask = mask_q;

endmodule

// File: tb/tb_guess_capture.sv
// Scoreboard bench for guess_capture: stimulus pushes the expected capture
// result and strobe cycle; a negedge monitor pops one entry per press strobe.
module tb_guess_capture;
  localparam int NC = 4;
  localparam int D  = 7;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [NC-1:0] btn;
  logic [NC*D-1:0] pattern;
  logic [2:0]    idx;
  logic          done;
  logic          press;
  logic [NC-1:0] press_mask;

  guess_capture #(
    .NUM_CH     (NC),
    .DEPTH      (D),
    .DEB_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .clear      (clear),
    .pattern    (pattern),
    .idx        (idx),
    .done       (done),
    .press      (press),
    .press_mask (press_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC*D-1:0] pat;
    logic [2:0]      idx;
    logic [NC-1:0]   mask;
    logic            done;
    int              cyc;
  } exp_t;

  exp_t            q[$];
  exp_t            me;
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  logic            prev_press = 1'b0;
  logic [NC*D-1:0] exp_pat;
  int              exp_idx;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation, and last one cycle.
  always @(negedge clk) begin
    if (press) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_press: cyc=%0d pattern=%h idx=%0d mask=%b", cyc, pattern, idx,
                 press_mask);
      end else begin
        me = q.pop_front();
        if (pattern !== me.pat || idx !== me.idx || press_mask !== me.mask || done !== me.done ||
            cyc != me.cyc) begin
          bad++;
          $display("FAIL capture: got pat=%h idx=%0d mask=%b done=%b cyc=%0d want pat=%h idx=%0d mask=%b done=%b cyc=%0d",
                   pattern, idx, press_mask, done, cyc, me.pat, me.idx, me.mask, me.done, me.cyc);
        end
      end
      total++;
      if (prev_press) begin
        bad++;
        $display("FAIL press_width: got press high two cycles want one (cyc=%0d)", cyc);
      end
    end
    prev_press = press;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    clear = 1'b0;
    btn   = '0;
    tick(2);
    rst     = 1'b0;
    exp_pat = '0;
    exp_idx = 0;
  endtask

  task automatic push_exp(input logic [NC-1:0] m, input int at);
    exp_t e;
    for (int c = 0; c < NC; c++) if (m[c]) exp_pat[c*D + exp_idx] = 1'b1;
    exp_idx++;
    e.pat  = exp_pat;
    e.idx  = 3'(exp_idx);
    e.mask = m;
    e.done = (exp_idx == D);
    e.cyc  = at;
    q.push_back(e);
  endtask

  // Hold mask m for 'hold' cycles then release long enough for debounce to settle.
  task automatic press_ch(input logic [NC-1:0] m, input int hold, input bit expect_write);
    @(negedge clk);
    btn = m;
    if (expect_write) push_exp(m, cyc + DB + 2);
    tick(hold);
    btn = '0;
    tick(10);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    btn   = '0;
    do_reset();
    chk("reset_pattern", 64'(pattern), 64'd0);
    chk("reset_idx", 64'(idx), 64'd0);
    chk("reset_done_press_mask", 64'({done, press, press_mask}), 64'd0);

    // Single press on channel 0 straight out of reset.
    press_ch(4'b0001, 10, 1'b1);
    wait_drain("single_drain");
    chk("single_pattern", 64'(pattern), 64'h0000001);
    chk("single_idx_mask", 64'({idx, press_mask}), 64'({3'd1, 4'b0001}));

    // Three-cycle glitch must be filtered.
    do_reset();
    press_ch(4'b0010, 3, 1'b0);
    wait_drain("glitch_drain");
    chk("glitch_pattern", 64'(pattern), 64'd0);
    chk("glitch_idx", 64'(idx), 64'd0);

    // Simultaneous channels 0 and 2 share one slot.
    do_reset();
    press_ch(4'b0101, 10, 1'b1);
    wait_drain("simul_drain");
    chk("simul_pattern", 64'(pattern), 64'h0004001);
    chk("simul_idx_mask", 64'({idx, press_mask}), 64'({3'd1, 4'b0101}));

    // Fill all slots on channel 3; the eighth press is ignored.
    do_reset();
    for (int i = 0; i < 7; i++) press_ch(4'b1000, 10, 1'b1);
    wait_drain("fill_drain");
    chk("fill_done", 64'({done, idx}), 64'({1'b1, 3'd7}));
    press_ch(4'b1000, 10, 1'b0);
    wait_drain("overflow_drain");
    chk("overflow_pattern", 64'(pattern), 64'hFE00000);
    chk("overflow_idx_done", 64'({done, idx}), 64'({1'b1, 3'd7}));
    chk("overflow_mask", 64'(press_mask), 64'(4'b1000));

    // Clear mid-round, then a fresh round starts at slot 0.
    do_reset();
    for (int i = 0; i < 3; i++) press_ch(4'b0001, 10, 1'b1);
    wait_drain("pre_clear_drain");
    chk("pre_clear_pattern", 64'(pattern), 64'h0000007);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_pattern", 64'(pattern), 64'd0);
    chk("clear_state", 64'({idx, done, press, press_mask}), 64'd0);
    exp_pat = '0;
    exp_idx = 0;
    press_ch(4'b0100, 10, 1'b1);
    wait_drain("post_clear_drain");
    chk("post_clear_pattern", 64'(pattern), 64'h0004000);
    chk("post_clear_idx_done", 64'({idx, done}), 64'({3'd1, 1'b0}));

    // Reset while channel 1 is mid-debounce with the button held.
    do_reset();
    @(negedge clk);
    btn = 4'b0010;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("midrst_pattern", 64'(pattern), 64'd0);
    chk("midrst_state", 64'({idx, done, press, press_mask}), 64'd0);
    rst     = 1'b0;
    exp_pat = '0;
    exp_idx = 0;
    push_exp(4'b0010, cyc + DB + 2);
    tick(12);
    btn = '0;
    tick(10);
    wait_drain("midrst_drain");
    chk("midrst_final", 64'(pattern), 64'h0000080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
